// File: rtl/reg_ctrl_pkg.sv
// Shared constants for the register1 access sequencer: FSM encoding and data width.
package reg_ctrl_pkg;

  localparam int unsigned REG_W = 256;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

endpackage

// File: rtl/reg_req_fifo.sv
// Request buffer for reg_access_ctrl: each entry holds {write flag, data}.
module reg_req_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH:0]                 push_data,
  input  logic                           pop,
  output logic [WIDTH:0]                 pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage is data-only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Sequences buffered read/write requests onto register1's Enable/ReadWrite
// interface and returns read data on a valid/ready response port.
module reg_access_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = REG_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             wr_ack,
  output logic             reg_enable,
  output logic             reg_readwrite,
  output logic [WIDTH-1:0] reg_data_in,
  input  logic [WIDTH-1:0] reg_data_out,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]       state_q, state_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             wr_ack_q, wr_ack_d;
  logic             en_q, en_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] din_q, din_d;

  logic             fifo_full, fifo_empty, fifo_pop, launch;
  logic [WIDTH:0]   fifo_head;
  logic [CntW-1:0]  fifo_count;

  reg_req_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (req_valid && req_ready),
    .push_data ({req_write, req_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
  assign req_ready     = !fifo_full;
  assign busy          = (fifo_count != '0) || (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign wr_ack        = wr_ack_q;
  assign reg_enable    = en_q;
  assign reg_readwrite = rw_q;
  assign reg_data_in   = din_q;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    wr_ack_d    = 1'b0;
    en_d        = en_q;
    rw_d        = rw_q;
    din_d       = din_q;
    launch      = 1'b0;

    case (state_q)
      IDLE: launch = !fifo_empty;
      WRITE: begin
        // register1 captures at this edge; ack in the following cycle.
        wr_ack_d = 1'b1;
        launch   = !fifo_empty;
        state_d  = IDLE;
        en_d     = 1'b0;
        rw_d     = 1'b1;
      end
      READ: begin
        rsp_data_d  = reg_data_out;
        rsp_valid_d = 1'b1;
        en_d        = 1'b0;
        rw_d        = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          launch      = !fifo_empty;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      en_d = 1'b1;
      if (fifo_head[WIDTH]) begin
        state_d = WRITE;
        rw_d    = 1'b0;
        din_d   = fifo_head[WIDTH-1:0];
      end else begin
        state_d = READ;
        rw_d    = 1'b1;
      end
    end
    fifo_pop = launch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_ack_q    <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= 1'b1;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wr_ack_q    <= wr_ack_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      din_q       <= din_d;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl with a behavioural register1 model.
module tb_reg_access_ctrl;

  localparam int unsigned W = 256;

  logic         clk;
  logic         reset;
  logic         req_valid, req_ready, req_write;
  logic [W-1:0] req_data;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         wr_ack, reg_enable, reg_readwrite, busy;
  logic [W-1:0] reg_data_in, reg_data_out;

  reg_access_ctrl #(
    .WIDTH      (W),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .wr_ack        (wr_ack),
    .reg_enable    (reg_enable),
    .reg_readwrite (reg_readwrite),
    .reg_data_in   (reg_data_in),
    .reg_data_out  (reg_data_out),
    .busy          (busy)
  );

  // register1: write at posedge, read data appears at negedge, storage not reset.
  logic [W-1:0] r1_mem;
  always @(posedge clk) if (reg_enable && !reg_readwrite) r1_mem <= reg_data_in;
  always @(negedge clk) if (reg_enable && reg_readwrite) reg_data_out <= r1_mem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl [10];
  logic [W-1:0] exp_q [$];
  int           n_cmp, n_err, n_ack, n0;
  bit           rand_rdy, seen_rsp;
  logic [W-1:0] a5, held;
  logic [7:0]   b;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One clock: observe at negedge (scoreboard), then drive #1 after posedge.
  task automatic step();
    @(negedge clk);
    if (wr_ack) n_ack++;
    if (rsp_valid) seen_rsp = 1'b1;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got data %h required no response", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic wr, input logic [W-1:0] d, input logic [W-1:0] e,
                      input bit track);
    int guard;
    guard     = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_data  = d;
    while (!req_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_accept_timeout: req_ready=0 required 1");
    end
    step();
    if (!wr && track) exp_q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin
      step();
      guard++;
    end
    chk_int("drain_pending", exp_q.size() + int'(busy), 0);
    step();
    step();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_ack = 0;
    rand_rdy = 1'b0; seen_rsp = 1'b0;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_data = '0; rsp_ready = 1'b1;
    a5 = {32{8'hA5}};
    for (int k = 0; k < 5; k++) begin
      b = 8'((k + 1) * 17);
      tbl[2*k]     = '{wr: 1'b1, data: {32{b}}, exp: '0};
      tbl[2*k + 1] = '{wr: 1'b0, data: '0, exp: {32{b}}};
    end

    // Reset values
    step(); step();
    chk1("rst_enable", reg_enable, 1'b0);
    chk1("rst_readwrite", reg_readwrite, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_data_in", reg_data_in, '0);
    reset = 1'b1;
    step();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);

    // Write A5 then read it back, with cycle-exact latency checks
    n0 = n_ack;
    send(1'b1, a5, '0, 1'b1);
    step();
    chk1("w_enable", reg_enable, 1'b1);
    chk1("w_readwrite", reg_readwrite, 1'b0);
    chk("w_data_in", reg_data_in, a5);
    chk1("w_ack_early", wr_ack, 1'b0);
    step();
    chk1("w_ack", wr_ack, 1'b1);
    chk1("w_enable_off", reg_enable, 1'b0);
    chk1("w_readwrite_off", reg_readwrite, 1'b1);
    step();
    chk1("w_ack_pulse", wr_ack, 1'b0);
    send(1'b0, '0, a5, 1'b1);
    step();
    chk1("r_enable", reg_enable, 1'b1);
    chk1("r_readwrite", reg_readwrite, 1'b1);
    chk1("r_valid_early", rsp_valid, 1'b0);
    step();
    chk1("r_valid", rsp_valid, 1'b1);
    chk("r_data", rsp_data, a5);
    drain();
    chk_int("wa_acks", n_ack - n0, 1);

    // Reset mid-stream with a stalled response and a queued write
    rsp_ready = 1'b0;
    n0 = n_ack;
    send(1'b0, '0, '0, 1'b0);
    send(1'b1, {32{8'h77}}, '0, 1'b0);
    step();
    chk1("mid_rsp_valid", rsp_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_data", rsp_data, '0);
    chk("mid_rst_data_in", reg_data_in, '0);
    chk1("mid_rst_enable", reg_enable, 1'b0);
    chk1("mid_rst_readwrite", reg_readwrite, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    repeat (3) step();
    chk1("mid_rst_wr_ack", wr_ack, 1'b0);
    reset = 1'b1;
    rsp_ready = 1'b1;
    seen_rsp = 1'b0;
    repeat (6) step();
    chk1("mid_no_rsp", seen_rsp, 1'b0);
    chk_int("mid_no_ack", n_ack - n0, 0);
    chk1("mid_ready", req_ready, 1'b1);

    // Back-to-back W(1), W(2), R
    n0 = n_ack;
    send(1'b1, W'(1), '0, 1'b1);
    send(1'b1, W'(2), '0, 1'b1);
    send(1'b0, '0, W'(2), 1'b1);
    drain();
    chk_int("b2b_acks", n_ack - n0, 2);

    // Response stall: FIFO fills behind a held response
    rsp_ready = 1'b0;
    send(1'b0, '0, W'(2), 1'b1);
    send(1'b0, '0, W'(2), 1'b1);
    send(1'b0, '0, W'(2), 1'b1);
    chk1("stall_full_ready", req_ready, 1'b0);
    chk1("stall_valid", rsp_valid, 1'b1);
    held = rsp_data;
    chk("stall_data", held, W'(2));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", rsp_data, held);
      chk1("stall_no_issue", reg_enable, 1'b0);
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk1("stall_valid_drop", rsp_valid, 1'b0);
    chk1("stall_next_issue", reg_enable, 1'b1);
    chk1("stall_no_comb_ready", req_ready, 1'b1);
    step();
    exp_q.push_back(W'(2));
    req_valid = 1'b0;
    drain();

    // FIFO wrap with random response back-pressure
    n0 = n_ack;
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) send(tbl[i].wr, tbl[i].data, tbl[i].exp, 1'b1);
    drain();
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    chk_int("wrap_acks", n_ack - n0, 5);

    // Reset during READ with a write queued behind it
    n0 = n_ack;
    send(1'b0, '0, '0, 1'b0);
    send(1'b1, W'(9), '0, 1'b0);
    chk1("rr_in_read_en", reg_enable, 1'b1);
    chk1("rr_in_read_rw", reg_readwrite, 1'b1);
    reset = 1'b0;
    #1;
    chk1("rr_enable", reg_enable, 1'b0);
    chk1("rr_busy", busy, 1'b0);
    chk1("rr_valid", rsp_valid, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    seen_rsp = 1'b0;
    repeat (6) step();
    chk1("rr_no_rsp", seen_rsp, 1'b0);
    chk_int("rr_no_ack", n_ack - n0, 0);
    chk1("rr_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
